// File: rtl/cpu_bus_pkg.sv
// rtl/cpu_bus_pkg.sv - shared types for the CPU Avalon bus arbiter
package cpu_bus_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUS_I,
    BUS_D,
    RESP
  } arb_state_t;

  typedef enum logic {
    GRANT_I,
    GRANT_D
  } grant_t;

  localparam logic [3:0] BE_WORD = 4'b1111;

endpackage

// File: rtl/avalon_bus_arbiter.sv
// rtl/avalon_bus_arbiter.sv - I/D requester arbiter onto one Avalon-MM master port
module avalon_bus_arbiter
  import cpu_bus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 11
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_read,
  input  logic [31:0] i_addr,
  output logic        i_done,
  output logic [31:0] i_rdata,
  input  logic        d_read,
  input  logic        d_write,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_be,
  output logic        d_done,
  output logic [31:0] d_rdata,
  output logic        err,
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic        waitrequest,
  input  logic [31:0] readdata,
  output logic        busy
);

  // Timer value on the last stalled cycle allowed before the abort fires.
  localparam logic [CNT_W-1:0] TIMER_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  arb_state_t       state, state_nxt;
  grant_t           grant, last_grant, win;
  logic [CNT_W-1:0] timer;
  logic             d_req;
  logic             timeout_hit;
  logic             start, finish, abort;

  assign d_req = d_read | d_write;
  assign busy  = (state != IDLE);

  // State register; reset drops any open bus cycle at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state, winner selection and the per-cycle control strobes.
  always_comb begin
    state_nxt   = state;
    start       = 1'b0;
    finish      = 1'b0;
    abort       = 1'b0;
    timeout_hit = (TIMEOUT_CYCLES != 0) && waitrequest && (timer == TIMER_LAST);
    if (i_read && d_req) win = (last_grant == GRANT_D) ? GRANT_I : GRANT_D;
    else if (i_read)     win = GRANT_I;
    else                 win = GRANT_D;
    case (state)
      IDLE: begin
        if (i_read || d_req) begin
          start     = 1'b1;
          state_nxt = (win == GRANT_I) ? BUS_I : BUS_D;
        end
      end
      BUS_I, BUS_D: begin
        if (!waitrequest) begin
          finish    = 1'b1;
          state_nxt = RESP;
        end else if (timeout_hit) begin
          abort     = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Registered bus drive, stall timer, read-data capture and done/err pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grant      <= GRANT_I;
      last_grant <= GRANT_D;
      timer      <= '0;
      address    <= '0;
      read       <= 1'b0;
      write      <= 1'b0;
      writedata  <= '0;
      byteenable <= '0;
      i_done     <= 1'b0;
      d_done     <= 1'b0;
      err        <= 1'b0;
      i_rdata    <= '0;
      d_rdata    <= '0;
    end else begin
      i_done  <= (finish || abort) && (grant == GRANT_I);
      d_done  <= (finish || abort) && (grant == GRANT_D);
      err     <= abort;
      i_rdata <= (finish && grant == GRANT_I) ? readdata : '0;
      d_rdata <= (finish && grant == GRANT_D && read) ? readdata : '0;

      if (start) begin
        grant <= win;
        timer <= '0;
        if (win == GRANT_I) begin
          address    <= i_addr;
          read       <= 1'b1;
          write      <= 1'b0;
          writedata  <= '0;
          byteenable <= BE_WORD;
        end else begin
          // A simultaneous read and write is served as a write.
          address    <= d_addr;
          read       <= ~d_write;
          write      <= d_write;
          writedata  <= d_wdata;
          byteenable <= d_be;
        end
      end

      if (finish || abort) begin
        read  <= 1'b0;
        write <= 1'b0;
      end else if ((state == BUS_I || state == BUS_D) && waitrequest) begin
        timer <= timer + CNT_W'(1);
      end

      if (state == RESP) begin
        last_grant <= grant;
        timer      <= '0;
      end
    end
  end

endmodule
